// File: rtl/fifo_pkg.sv
// ---------------------------------------------------------------------------
// fifo_pkg
//   Shared helpers for the dual-clock FIFO (read and write controllers).
//   - ptr_width : pointer width for a given RAM address width (one extra MSB
//                 distinguishes full from empty).
//   - bin2gray / gray2bin : code conversion on a wide container. Callers
//                 zero-extend their pointer and cast the result back down.
//                 Both conversions are exact under zero extension.
// ---------------------------------------------------------------------------
package fifo_pkg;

    localparam int GRAY_MAX_W = 32;

    function automatic int ptr_width(input int address_width);
        return address_width + 1;
    endfunction

    function automatic logic [GRAY_MAX_W-1:0] bin2gray(input logic [GRAY_MAX_W-1:0] bin);
        return bin ^ (bin >> 1);
    endfunction

    function automatic logic [GRAY_MAX_W-1:0] gray2bin(input logic [GRAY_MAX_W-1:0] gray);
        logic [GRAY_MAX_W-1:0] bin;
        bin[GRAY_MAX_W-1] = gray[GRAY_MAX_W-1];
        for (int i = GRAY_MAX_W - 2; i >= 0; i--) begin
            bin[i] = bin[i+1] ^ gray[i];
        end
        return bin;
    endfunction

endpackage

// File: rtl/pointer_synchronizer.sv
// ---------------------------------------------------------------------------
// pointer_synchronizer
//   Two-flop synchronizer for a Gray-coded pointer crossing into the
//   clock domain. Only one bit changes per source increment, so a
//   bus-wide flop pair is safe.
//   Ports:
//     clock     in   destination-domain clock
//     reset_n   in   asynchronous active-low reset
//     async_in  in   WIDTH  Gray pointer from the other domain
//     sync_out  out  WIDTH  synchronized pointer (two clocks of latency)
// ---------------------------------------------------------------------------
module pointer_synchronizer #(
    parameter int WIDTH = 5
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] async_in,
    output logic [WIDTH-1:0] sync_out
);

    logic [WIDTH-1:0] stage1;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            stage1   <= '0;
            sync_out <= '0;
        end else begin
            stage1   <= async_in;
            sync_out <= stage1;
        end
    end

endmodule

// File: rtl/fifo_read_controller.sv
// ---------------------------------------------------------------------------
// fifo_read_controller
//   Read side of the dual-clock FIFO. Owns the read pointer and empty flag,
//   addresses the RAM, and registers the RAM word into a first-word-fall-
//   through valid/ready output stage.
//   Ports:
//     clock              in   read-domain clock
//     reset_n            in   asynchronous active-low reset
//     write_pointer_gray in   AW+1  Gray write pointer (asynchronous)
//     ram_read_data      in   DW    combinational RAM data at read_address
//     read_ready         in   consumer accepts output_data
//     read_address       out  AW    RAM read address
//     read_pointer_gray  out  AW+1  registered Gray read pointer
//     empty              out  no unread word left in the RAM
//     output_valid       out  output_data holds a word
//     output_data        out  DW    head-of-FIFO word
//     fill_level         out  AW+1  words in RAM not yet loaded
// ---------------------------------------------------------------------------
module fifo_read_controller
    import fifo_pkg::*;
#(
    parameter int DATA_WIDTH    = 32,
    parameter int ADDRESS_WIDTH = 4
) (
    input  logic                       clock,
    input  logic                       reset_n,
    input  logic [ADDRESS_WIDTH:0]     write_pointer_gray,
    input  logic [DATA_WIDTH-1:0]      ram_read_data,
    input  logic                       read_ready,
    output logic [ADDRESS_WIDTH-1:0]   read_address,
    output logic [ADDRESS_WIDTH:0]     read_pointer_gray,
    output logic                       empty,
    output logic                       output_valid,
    output logic [DATA_WIDTH-1:0]      output_data,
    output logic [ADDRESS_WIDTH:0]     fill_level
);

    localparam int PW = ptr_width(ADDRESS_WIDTH);

    logic [PW-1:0] read_pointer_binary;
    logic [PW-1:0] read_pointer_binary_next;
    logic [PW-1:0] read_pointer_gray_next;
    logic [PW-1:0] write_pointer_sync_gray;
    logic [PW-1:0] write_pointer_sync_binary;
    logic          load;

    pointer_synchronizer #(
        .WIDTH (PW)
    ) u_write_pointer_sync (
        .clock    (clock),
        .reset_n  (reset_n),
        .async_in (write_pointer_gray),
        .sync_out (write_pointer_sync_gray)
    );

    // Output stage refills whenever it is empty or being drained, so a
    // continuously-ready consumer sees one word per clock.
    always_comb begin
        load                      = !empty && (!output_valid || read_ready);
        read_pointer_binary_next  = read_pointer_binary + PW'(load);
        read_pointer_gray_next    = PW'(bin2gray(GRAY_MAX_W'(read_pointer_binary_next)));
        write_pointer_sync_binary = PW'(gray2bin(GRAY_MAX_W'(write_pointer_sync_gray)));
    end

    assign read_address = read_pointer_binary[ADDRESS_WIDTH-1:0];

    // empty and fill_level look at the post-load pointer, so a load and a
    // write-pointer advance in the same cycle both count. Comparing against
    // the synchronized (late) write pointer means empty can only be
    // pessimistic.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            read_pointer_binary <= '0;
            read_pointer_gray   <= '0;
            empty               <= 1'b1;
            fill_level          <= '0;
            output_valid        <= 1'b0;
            output_data         <= '0;
        end else begin
            read_pointer_binary <= read_pointer_binary_next;
            read_pointer_gray   <= read_pointer_gray_next;
            empty               <= (read_pointer_gray_next == write_pointer_sync_gray);
            fill_level          <= write_pointer_sync_binary - read_pointer_binary_next;
            if (load) begin
                output_data  <= ram_read_data;
                output_valid <= 1'b1;
            end else if (output_valid && read_ready) begin
                output_valid <= 1'b0;
            end
        end
    end

endmodule
